// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, coin values and coin summing for the vending sequencer.
package vend_pkg;
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_e;
    localparam logic [3:0] COIN1 = 4'd1;
    localparam logic [3:0] COIN2 = 4'd2;
    localparam logic [3:0] COIN5 = 4'd5;
    function automatic logic [3:0] coin_sum(input logic r1, input logic r2, input logic r5);
        return (r1 ? COIN1 : 4'd0) + (r2 ? COIN2 : 4'd0) + (r5 ? COIN5 : 4'd0);
    endfunction
endpackage

// File: rtl/vend_change_picker.sv
// vend_change_picker: greedy choice of the next change coin for the remaining credit.
module vend_change_picker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic                pick5_o,
    output logic                pick2_o,
    output logic                pick1_o,
    output logic [3:0]          value_o
);
    assign pick5_o = credit_i >= CREDIT_W'(COIN5);
    assign pick2_o = !pick5_o && credit_i >= CREDIT_W'(COIN2);
    assign pick1_o = !pick5_o && !pick2_o;
    assign value_o = pick5_o ? COIN5 : pick2_o ? COIN2 : COIN1;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit accumulation, item vend and greedy change/refund payout.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE0     = 10,
    parameter int PRICE1     = 12,
    parameter int PRICE2     = 15,
    parameter int PRICE3     = 20,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 30
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                rupee1_i,
    input  logic                rupee2_i,
    input  logic                rupee5_i,
    input  logic                sel_valid_i,
    input  logic [1:0]          sel_item_i,
    input  logic                cancel_i,
    input  logic                return_ready_i,
    output logic                dispense_o,
    output logic [1:0]          item_out_o,
    output logic                ret1_o,
    output logic                ret2_o,
    output logic                ret5_o,
    output logic                coin_reject_o,
    output logic                sel_denied_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o
);
    function automatic logic [CREDIT_W-1:0] price(input logic [1:0] i);
        return i == 2'd0 ? CREDIT_W'(PRICE0) : i == 2'd1 ? CREDIT_W'(PRICE1) :
               i == 2'd2 ? CREDIT_W'(PRICE2) : CREDIT_W'(PRICE3);
    endfunction

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [1:0]          item_q;
    logic                coin_reject_q;
    logic                sel_denied_q;
    logic [3:0]          coins;
    logic [CREDIT_W:0]   sum_w;
    logic                over;
    logic                afford;
    logic                cancel_take;
    logic [CREDIT_W-1:0] vend_left;
    logic                pick5;
    logic                pick2;
    logic                pick1;
    logic [3:0]          coin_val;
    logic                pay;

    vend_change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
        .credit_i (credit_q),
        .pick5_o  (pick5),
        .pick2_o  (pick2),
        .pick1_o  (pick1),
        .value_o  (coin_val)
    );

    // sum carries one extra bit so an overflowing coin burst is still detected
    assign coins       = coin_sum(rupee1_i, rupee2_i, rupee5_i);
    assign sum_w       = {1'b0, credit_q} + (CREDIT_W+1)'(coins);
    assign over        = sum_w > (CREDIT_W+1)'(MAX_CREDIT);
    assign afford      = credit_q >= price(sel_item_i);
    assign cancel_take = cancel_i && credit_q != '0;
    assign vend_left   = credit_q - price(item_q);
    assign pay         = state_q == CHANGE && return_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= COLLECT;
            credit_q      <= '0;
            item_q        <= '0;
            coin_reject_q <= 1'b0;
            sel_denied_q  <= 1'b0;
        end else begin
            coin_reject_q <= coins != 4'd0 && (state_q != COLLECT || over);
            sel_denied_q  <= state_q == COLLECT && !cancel_take && sel_valid_i && !afford;
            case (state_q)
                COLLECT: begin
                    if (!over) credit_q <= sum_w[CREDIT_W-1:0];
                    if (cancel_take) state_q <= CHANGE;
                    else if (sel_valid_i && afford) begin
                        state_q <= VEND;
                        item_q  <= sel_item_i;
                    end
                end
                VEND: begin
                    credit_q <= vend_left;
                    state_q  <= vend_left != '0 ? CHANGE : COLLECT;
                end
                CHANGE: if (return_ready_i) begin
                    credit_q <= credit_q - CREDIT_W'(coin_val);
                    if (credit_q == CREDIT_W'(coin_val)) state_q <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign dispense_o    = state_q == VEND;
    assign item_out_o    = dispense_o ? item_q : 2'd0;
    assign ret5_o        = pay && pick5;
    assign ret2_o        = pay && pick2;
    assign ret1_o        = pay && pick1;
    assign coin_reject_o = coin_reject_q;
    assign sel_denied_o  = sel_denied_q;
    assign credit_o      = credit_q;
    assign busy_o        = state_q != COLLECT;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: table-driven directed check of the vending sequencer plus async reset corners.
module tb_vend_sequencer;
    localparam logic [7:0] R1 = 8'h80, R2 = 8'h40, R5 = 8'h20, SEL = 8'h10;
    localparam logic [7:0] I1 = 8'h04, I3 = 8'h0C, CAN = 8'h02, RDY = 8'h01;

    typedef struct {
        logic [7:0]  in;
        logic [14:0] exp;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       rupee1_i = 1'b0, rupee2_i = 1'b0, rupee5_i = 1'b0;
    logic       sel_valid_i = 1'b0, cancel_i = 1'b0, return_ready_i = 1'b0;
    logic [1:0] sel_item_i = 2'd0;
    logic       dispense_o, ret1_o, ret2_o, ret5_o, coin_reject_o, sel_denied_o, busy_o;
    logic [1:0] item_out_o;
    logic [5:0] credit_o;
    int         checks = 0;
    int         errors = 0;
    vec_t       tv[$];

    vend_sequencer dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .rupee1_i       (rupee1_i),
        .rupee2_i       (rupee2_i),
        .rupee5_i       (rupee5_i),
        .sel_valid_i    (sel_valid_i),
        .sel_item_i     (sel_item_i),
        .cancel_i       (cancel_i),
        .return_ready_i (return_ready_i),
        .dispense_o     (dispense_o),
        .item_out_o     (item_out_o),
        .ret1_o         (ret1_o),
        .ret2_o         (ret2_o),
        .ret5_o         (ret5_o),
        .coin_reject_o  (coin_reject_o),
        .sel_denied_o   (sel_denied_o),
        .credit_o       (credit_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic [7:0] in, input logic d, input logic [1:0] it,
                                input logic [2:0] ret, input logic rej, input logic den,
                                input logic [5:0] cr, input logic b);
        vec_t v;
        v.in  = in;
        v.exp = {d, it, ret, rej, den, cr, b};
        return v;
    endfunction

    function automatic logic [14:0] actual();
        return {dispense_o, item_out_o, ret5_o, ret2_o, ret1_o, coin_reject_o, sel_denied_o, credit_o, busy_o};
    endfunction

    task automatic drive(input logic [7:0] in);
        {rupee1_i, rupee2_i, rupee5_i, sel_valid_i, sel_item_i, cancel_i, return_ready_i} = in;
    endtask

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {disp,item,ret521,rej,den,credit,busy}=%b_%b_%b_%b_%b_%0d_%b required %b_%b_%b_%b_%b_%0d_%b",
                     name, act[14], act[13:12], act[11:9], act[8], act[7], act[6:1], act[0],
                     exp[14], exp[13:12], exp[11:9], exp[8], exp[7], exp[6:1], exp[0]);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        drive(v.in);
        @(negedge clk_i);
        check(name, v.exp);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // two fives then item 0: exact-price vend, no change
        tv.push_back(mk(R5, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(R5, 0, 0, 0, 0, 0, 5, 0));
        tv.push_back(mk(SEL | RDY, 0, 0, 0, 0, 0, 10, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // 12 credit, item 0, then 2-rupee change
        tv.push_back(mk(R5, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(R5, 0, 0, 0, 0, 0, 5, 0));
        tv.push_back(mk(R2, 0, 0, 0, 0, 0, 10, 0));
        tv.push_back(mk(SEL | RDY, 0, 0, 0, 0, 0, 12, 0));
        tv.push_back(mk(RDY, 1, 0, 0, 0, 0, 12, 1));
        tv.push_back(mk(RDY, 0, 0, 3'b010, 0, 0, 2, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // simultaneous coins sum to 8, cancel refunds 5,2,1
        tv.push_back(mk(R1 | R2 | R5 | RDY, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(CAN | RDY, 0, 0, 0, 0, 0, 8, 0));
        tv.push_back(mk(RDY, 0, 0, 3'b100, 0, 0, 8, 1));
        tv.push_back(mk(RDY, 0, 0, 3'b010, 0, 0, 3, 1));
        tv.push_back(mk(RDY, 0, 0, 3'b001, 0, 0, 1, 1));
        tv.push_back(mk(RDY, 0, 0, 0, 0, 0, 0, 0));
        // refund of 8 stalled three cycles by the hopper
        tv.push_back(mk(R5, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(R2, 0, 0, 0, 0, 0, 5, 0));
        tv.push_back(mk(R1, 0, 0, 0, 0, 0, 7, 0));
        tv.push_back(mk(CAN, 0, 0, 0, 0, 0, 8, 0));
        for (int i = 0; i < 3; i++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 8, 1));
        tv.push_back(mk(RDY, 0, 0, 3'b100, 0, 0, 8, 1));
        tv.push_back(mk(RDY, 0, 0, 3'b010, 0, 0, 3, 1));
        tv.push_back(mk(RDY, 0, 0, 3'b001, 0, 0, 1, 1));
        tv.push_back(mk(RDY, 0, 0, 0, 0, 0, 0, 0));
        // credit 28: a five overflows and is refused, a two lands exactly on 30
        for (int i = 0; i < 5; i++) tv.push_back(mk(R5, 0, 0, 0, 0, 0, 6'(5 * i), 0));
        tv.push_back(mk(R2, 0, 0, 0, 0, 0, 25, 0));
        tv.push_back(mk(R1, 0, 0, 0, 0, 0, 27, 0));
        tv.push_back(mk(R5, 0, 0, 0, 0, 0, 28, 0));
        tv.push_back(mk(R2, 0, 0, 0, 1, 0, 28, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 30, 0));
        tv.push_back(mk(CAN | RDY, 0, 0, 0, 0, 0, 30, 0));
        for (int i = 0; i < 6; i++) tv.push_back(mk(RDY, 0, 0, 3'b100, 0, 0, 6'(30 - 5 * i), 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // low credit denial, cancel beating select, coin refused during change
        tv.push_back(mk(R5, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(R2, 0, 0, 0, 0, 0, 5, 0));
        tv.push_back(mk(SEL | I1, 0, 0, 0, 0, 0, 7, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0));
        tv.push_back(mk(CAN | SEL | I1 | RDY, 0, 0, 0, 0, 0, 7, 0));
        tv.push_back(mk(R1 | RDY, 0, 0, 3'b100, 0, 0, 7, 1));
        tv.push_back(mk(RDY, 0, 0, 3'b010, 1, 0, 2, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // item 3 at exact price; cancel, select and coin during vend are ignored/refused
        for (int i = 0; i < 4; i++) tv.push_back(mk(R5, 0, 0, 0, 0, 0, 6'(5 * i), 0));
        tv.push_back(mk(SEL | I3, 0, 0, 0, 0, 0, 20, 0));
        tv.push_back(mk(SEL | CAN | R1, 1, 3, 0, 0, 0, 20, 1));
        tv.push_back(mk(CAN | RDY, 0, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        #3;
        check("reset_state", 15'd0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        foreach (tv[i]) step($sformatf("vec%0d", i), tv[i]);

        // reset in the middle of a stalled change with credit 3
        step("rst_prep0", mk(R2, 0, 0, 0, 0, 0, 0, 0));
        step("rst_prep1", mk(R1, 0, 0, 0, 0, 0, 2, 0));
        step("rst_prep2", mk(CAN, 0, 0, 0, 0, 0, 3, 0));
        step("rst_prep3", mk(0, 0, 0, 0, 0, 0, 3, 1));
        drive(R5 | RDY);
        #1 check("pre_reset_ret2", {1'b0, 2'd0, 3'b010, 1'b0, 1'b0, 6'd3, 1'b1});
        #1 reset_i = 1'b1;
        #1 check("async_reset", 15'd0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        drive(0);
        @(negedge clk_i);
        check("post_reset", 15'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Control block for the coin vending datapath. It accepts 1/2/5-rupee coin pulses and accumulates credit. It serves a 4-item selection against a parameterised price table, pulses dispense, and then pays out change or a cancel refund as one coin pulse per cycle to a coin hopper under a ready handshake. It sits between the coin sensors and selection keypad on one side and the dispense actuator and hopper on the other.

Parameters:
PRICE0, 10, price of item 0 in rupees
PRICE1, 12, price of item 1
PRICE2, 15, price of item 2
PRICE3, 20, price of item 3
CREDIT_W, 6, credit register width
MAX_CREDIT, 30, maximum credit held; must be <= 2^CREDIT_W-1 and >= every PRICEn

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rupee1  input  1  1-rupee coin pulse, one cycle per coin
rupee2  input  1  2-rupee coin pulse
rupee5  input  1  5-rupee coin pulse
sel_valid  input  1  item selection strobe
sel_item  input  2  selected item index
cancel  input  1  refund request
return_ready  input  1  hopper can accept a coin pulse this cycle
dispense  output  1  one-cycle vend pulse
item_out  output  2  item being vended, valid while dispense=1
ret1  output  1  pay out a 1-rupee coin
ret2  output  1  pay out a 2-rupee coin
ret5  output  1  pay out a 5-rupee coin
coin_reject  output  1  coins this cycle refused (registered, next cycle)
sel_denied  output  1  selection refused for low credit (registered, next cycle)
credit  output  CREDIT_W  current credit
busy  output  1  high when state != COLLECT

Behaviour:
- Reset (async, active-high):
  - state=COLLECT, credit=0.
  - dispense, item_out, ret1/2/5, coin_reject, sel_denied all 0.
  - Reset mid-VEND or mid-CHANGE drops the remaining change and clears credit.
- States: COLLECT, VEND, CHANGE.
- Coin sum per cycle: s = rupee1*1 + rupee2*2 + rupee5*5. Simultaneous coins are all summed (max 8).
- Coin acceptance in COLLECT:
  - credit+s <= MAX_CREDIT: credit += s at the clock edge.
  - Otherwise the whole cycle's coins are refused: credit unchanged, coin_reject=1 in the next cycle.
- Coins in VEND or CHANGE are always refused: coin_reject=1 in the next cycle.
- COLLECT, priority cancel > sel_valid:
  - cancel=1 and credit>0 -> CHANGE (refund). cancel with credit=0 is ignored.
  - sel_valid=1 with credit >= PRICE[sel_item] -> VEND; latch sel_item.
  - sel_valid=1 with credit < PRICE[sel_item] -> stay in COLLECT; sel_denied=1 in the next cycle.
  - Comparisons use the pre-edge credit. Same-cycle coins are still added if accepted.
- VEND, exactly one cycle (Moore):
  - dispense=1, item_out=latched item.
  - At the edge, credit -= price.
  - Next state is CHANGE if the result is >0, else COLLECT.
- Selection latency: sel_valid sampled at edge N -> dispense high for the cycle after edge N.
- CHANGE, greedy payout:
  - Pick coin c = 5 if credit>=5, else 2 if credit>=2, else 1.
  - When return_ready=1, assert the matching retN combinationally that cycle (Mealy) and credit -= c at the edge.
  - When return_ready=0, all ret outputs are 0 and credit is held (stall).
  - At most one ret output is high per cycle.
  - Leave for COLLECT on the edge where credit becomes 0.
- sel_valid and cancel are ignored outside COLLECT.
- Width: credit never exceeds MAX_CREDIT. Subtraction never underflows, guaranteed by the checks above.

Decomposition:
- vend_pkg holds:
  - state enum {COLLECT, VEND, CHANGE}
  - coin value constants 1/2/5
  - function coin_sum(r1, r2, r5)
- Sub-module vend_change_picker: combinational, credit in -> one-hot {pick5, pick2, pick1} plus coin value out. Used by CHANGE.

Test Plan:
- rupee5, rupee5, then sel_item=0 -> credit 10. dispense=1 with item_out=0 for one cycle, credit 0, no ret pulses, back to COLLECT.
- rupee5 x2, rupee2, then sel_item=0 with return_ready=1 -> dispense, then ret2 for one cycle, credit 0.
- Credit 8 (5+2+1), cancel -> ret5, ret2, ret1 on three consecutive cycles, then busy=0.
- Credit 8, cancel, return_ready held 0 for 3 cycles -> no ret pulses, credit stays 8. Release -> ret5, ret2, ret1 as before.
- rupee1+rupee2+rupee5 asserted in the same cycle -> credit +8.
- Credit 28, rupee5 -> coin_reject=1 next cycle, credit 28.
- Credit 7, sel_item=1 (price 12) -> sel_denied=1, no dispense.
- Coin during CHANGE -> coin_reject.
- Reset asserted mid-CHANGE with credit 3 -> immediately credit 0, all outputs 0, state COLLECT.
